// File: rtl/regfile_sb.sv
// regfile_sb: parametrised multi-read-port register file with write-to-read
// bypass, a per-register pending-write scoreboard and an LED register tap.
module regfile_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned TAP_REG    = 16,
  parameter int unsigned TAP_WIDTH  = 16
) (
  input  logic                           clock,
  input  logic                           ctrl_reset_n,
  input  logic                           ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0]          data_writeReg,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
  output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
  output logic [NUM_READ-1:0]            busy_read,
  input  logic                           ctrl_reserveEnable,
  input  logic [ADDR_WIDTH-1:0]          ctrl_reserveReg,
  output logic [ADDR_WIDTH:0]            busy_count,
  output logic [TAP_WIDTH-1:0]           LED
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] TAP_IDX = ADDR_WIDTH'(TAP_REG);
  localparam bit HAS_ZERO = (ZERO_REG != 0);
  localparam bit HAS_BYP  = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [CNT_W-1:0]      count_q;
  logic                  wr_ok;
  logic                  rsv_ok;
  logic                  cnt_inc;
  logic                  cnt_dec;

  // Writes and reserves to a hard-wired zero register are dropped.
  assign wr_ok  = ctrl_writeEnable   && !(HAS_ZERO && (ctrl_writeReg   == '0));
  assign rsv_ok = ctrl_reserveEnable && !(HAS_ZERO && (ctrl_reserveReg == '0));

  // Net scoreboard delta; a write clearing a bit that is re-reserved this edge is not a release.
  assign cnt_inc = rsv_ok && !busy[ctrl_reserveReg];
  assign cnt_dec = wr_ok && busy[ctrl_writeReg] &&
                   !(rsv_ok && (ctrl_reserveReg == ctrl_writeReg));

  // Register storage.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[ctrl_writeReg] <= data_writeReg;
    end
  end

  // Busy bits: the reserve is applied last so a newer producer wins on a same-index collision.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      busy <= '0;
    end else begin
      if (wr_ok)  busy[ctrl_writeReg]   <= 1'b0;
      if (rsv_ok) busy[ctrl_reserveReg] <= 1'b1;
    end
  end

  // Running popcount of the busy bits, maintained incrementally.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) count_q <= '0;
    else               count_q <= count_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
  end

  assign busy_count = count_q;
  assign LED        = TAP_WIDTH'(regs[TAP_IDX]);

  // Per-port combinational read with bypass and zero-register override.
  for (genvar k = 0; k < int'(NUM_READ); k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] idx;
    logic                  is_zero;
    logic                  hit;

    assign idx     = ctrl_readReg[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign is_zero = HAS_ZERO && (idx == '0);
    assign hit     = HAS_BYP && ctrl_writeEnable && (ctrl_writeReg == idx) && !is_zero;

    assign data_readReg[k*DATA_WIDTH +: DATA_WIDTH] =
      is_zero ? '0 : (hit ? data_writeReg : regs[idx]);
    assign busy_read[k] = !is_zero && !hit && busy[idx];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb: default build, a BYPASS=0 build
// sharing its inputs, and a narrow 4-port build.
module tb_regfile_sb;

  logic        clock;
  logic        rst_n;
  logic        we, rsv;
  logic [4:0]  wr, rr;
  logic [31:0] wd;
  logic [9:0]  rd;
  logic [63:0] dout, dout_nb;
  logic [1:0]  br, br_nb;
  logic [5:0]  bc, bc_nb;
  logic [15:0] led, led_nb;

  logic        sw_we, sw_rsv;
  logic [2:0]  sw_wr, sw_rr;
  logic [15:0] sw_wd;
  logic [11:0] sw_rd;
  logic [63:0] sw_dout;
  logic [3:0]  sw_br;
  logic [3:0]  sw_bc;
  logic [15:0] sw_led;

  int n_vec = 0;
  int n_err = 0;

  regfile_sb u_dut (
    .clock(clock), .ctrl_reset_n(rst_n),
    .ctrl_writeEnable(we), .ctrl_writeReg(wr), .data_writeReg(wd),
    .ctrl_readReg(rd), .data_readReg(dout), .busy_read(br),
    .ctrl_reserveEnable(rsv), .ctrl_reserveReg(rr),
    .busy_count(bc), .LED(led)
  );

  regfile_sb #(.BYPASS(0)) u_nb (
    .clock(clock), .ctrl_reset_n(rst_n),
    .ctrl_writeEnable(we), .ctrl_writeReg(wr), .data_writeReg(wd),
    .ctrl_readReg(rd), .data_readReg(dout_nb), .busy_read(br_nb),
    .ctrl_reserveEnable(rsv), .ctrl_reserveReg(rr),
    .busy_count(bc_nb), .LED(led_nb)
  );

  regfile_sb #(.NUM_READ(4), .DATA_WIDTH(16), .ADDR_WIDTH(3), .TAP_REG(5)) u_sw (
    .clock(clock), .ctrl_reset_n(rst_n),
    .ctrl_writeEnable(sw_we), .ctrl_writeReg(sw_wr), .data_writeReg(sw_wd),
    .ctrl_readReg(sw_rd), .data_readReg(sw_dout), .busy_read(sw_br),
    .ctrl_reserveEnable(sw_rsv), .ctrl_reserveReg(sw_rr),
    .busy_count(sw_bc), .LED(sw_led)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; we = 0; rsv = 0; wr = '0; rr = '0; wd = '0; rd = '0;
    sw_we = 0; sw_rsv = 0; sw_wr = '0; sw_rr = '0; sw_wd = '0; sw_rd = '0;
    #2;
    // reset state: sweep every index on both ports
    for (int i = 0; i < 32; i++) begin
      rd = {5'(31 - i), 5'(i)};
      #1;
      chk("rst_p0", dout[31:0], 64'h0);
      chk("rst_p1", dout[63:32], 64'h0);
      chk("rst_busy", 64'(br), 64'h0);
    end
    chk("rst_count", 64'(bc), 64'h0);
    chk("rst_led", 64'(led), 64'h0);
    @(negedge clock);
    rst_n = 1'b1;

    // write r5, read next cycle on port 1
    we = 1; wr = 5'd5; wd = 32'hDEADBEEF;
    tick();
    we = 0; rd = {5'd5, 5'd0};
    #1;
    chk("r5_p1", dout[63:32], 64'hDEADBEEF);

    // write to r0 must neither bypass nor stick
    we = 1; wr = 5'd0; wd = 32'h1234;
    #1;
    chk("r0_bypass", dout[31:0], 64'h0);
    tick();
    we = 0;
    #1;
    chk("r0_stored", dout[31:0], 64'h0);

    // bypass versus no-bypass build
    we = 1; wr = 5'd7; wd = 32'hA5A5A5A5; rd = {5'd5, 5'd7};
    #1;
    chk("byp_on", dout[31:0], 64'hA5A5A5A5);
    chk("byp_off", dout_nb[31:0], 64'h0);
    tick();
    we = 0;
    #1;
    chk("r7_nb_stored", dout_nb[31:0], 64'hA5A5A5A5);

    // reserve r3: invisible this cycle, visible next
    rsv = 1; rr = 5'd3; rd = {5'd3, 5'd7};
    #1;
    chk("rsv_same_cycle", 64'(br), 64'h0);
    tick();
    rsv = 0;
    #1;
    chk("rsv_busy", 64'(br), 64'b10);
    chk("rsv_count", 64'(bc), 64'd1);

    // write r3: bypass clears busy combinationally, then storage clears it
    we = 1; wr = 5'd3; wd = 32'h33;
    #1;
    chk("wr_byp_busy", 64'(br), 64'b00);
    chk("wr_nb_busy", 64'(br_nb), 64'b10);
    tick();
    we = 0;
    #1;
    chk("wr_busy_clr", 64'(br), 64'b00);
    chk("wr_count", 64'(bc), 64'd0);

    // reserve r3 again, then reserve+write r3 together
    rsv = 1; rr = 5'd3;
    tick();
    we = 1; wr = 5'd3; wd = 32'h77;
    tick();
    we = 0; rsv = 0;
    #1;
    chk("coll_data", dout[63:32], 64'h77);
    chk("coll_busy", 64'(br), 64'b10);
    chk("coll_count", 64'(bc), 64'd1);

    // write r3 while reserving r9: independent, count nets to 1
    we = 1; wr = 5'd3; wd = 32'h88; rsv = 1; rr = 5'd9;
    tick();
    we = 0; rd = {5'd9, 5'd3};
    #1;
    chk("split_busy", 64'(br), 64'b10);
    chk("split_count", 64'(bc), 64'd1);
    // re-reserve an already busy r9: no double count
    tick();
    rsv = 0;
    #1;
    chk("rersv_count", 64'(bc), 64'd1);
    we = 1; wr = 5'd9; wd = 32'h99;
    tick();
    we = 0;
    #1;
    chk("r9_release", 64'(bc), 64'd0);

    // reserve of r0 ignored
    rsv = 1; rr = 5'd0; rd = {5'd0, 5'd0};
    tick();
    rsv = 0;
    #1;
    chk("r0_rsv_busy", 64'(br), 64'b00);
    chk("r0_rsv_count", 64'(bc), 64'd0);

    // LED tap
    we = 1; wr = 5'd16; wd = 32'h0001ABCD;
    #1;
    chk("led_no_bypass", 64'(led), 64'h0);
    tick();
    we = 0;
    #1;
    chk("led", 64'(led), 64'hABCD);
    chk("led_nb", 64'(led_nb), 64'hABCD);

    // reserve r1, r2, r4 then async reset between edges
    rsv = 1; rr = 5'd1; tick();
    rr = 5'd2; tick();
    rr = 5'd4; tick();
    rsv = 0; rd = {5'd5, 5'd1};
    #1;
    chk("three_count", 64'(bc), 64'd3);
    chk("three_busy", 64'(br), 64'b01);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(bc), 64'd0);
    chk("arst_busy", 64'(br), 64'b00);
    chk("arst_p1", dout[63:32], 64'h0);
    chk("arst_led", 64'(led), 64'h0);
    // edge under reset: write/reserve discarded
    rsv = 1; rr = 5'd6; rd = {5'd5, 5'd6};
    tick();
    rsv = 0;
    #1;
    chk("hold_busy", 64'(br), 64'b00);
    chk("hold_count", 64'(bc), 64'd0);
    // first edge after release performs the write
    @(negedge clock);
    rst_n = 1'b1; we = 1; wr = 5'd5; wd = 32'h55;
    tick();
    we = 0;
    #1;
    chk("post_rst_wr", dout[63:32], 64'h55);

    // narrow 4-port build: fill r1..r7
    for (int i = 1; i < 8; i++) begin
      sw_we = 1; sw_wr = 3'(i); sw_wd = 16'(16'h1110 + i);
      tick();
    end
    sw_we = 0;
    sw_rd = {3'd0, 3'd3, 3'd5, 3'd7};
    #1;
    chk("sw_p0", 64'(sw_dout[15:0]),  64'h1117);
    chk("sw_p1", 64'(sw_dout[31:16]), 64'h1115);
    chk("sw_p2", 64'(sw_dout[47:32]), 64'h1113);
    chk("sw_p3", 64'(sw_dout[63:48]), 64'h0);
    chk("sw_led", 64'(sw_led), 64'h1115);
    // reserve every index (r0 ignored) plus r7 twice
    for (int i = 0; i < 8; i++) begin
      sw_rsv = 1; sw_rr = 3'(i);
      tick();
    end
    sw_rr = 3'd7;
    tick();
    sw_rsv = 0;
    #1;
    chk("sw_count_max", 64'(sw_bc), 64'd7);
    chk("sw_busy", 64'(sw_br), 64'b0111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised, multi-read-port register file with write-to-read bypass and a per-register pending-write scoreboard. It is the successor to the fixed 32x32, two-read-port CPU register file. It sits in the decode stage of the pipelined processor. Decode reads operands and reserves destinations; writeback writes results and releases them. A configurable register tap drives the board LEDs.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH
- NUM_READ, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 is hard-wired to 0 and never busy
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads
- TAP_REG, 16, register index mirrored on LED
- TAP_WIDTH, 16, LED width; LED = reg[TAP_REG][TAP_WIDTH-1:0]

Ports:
- clock  in  1  single clock, rising edge
- ctrl_reset_n  in  1  asynchronous, active-low reset
- ctrl_writeEnable  in  1  writeback strobe
- ctrl_writeReg  in  ADDR_WIDTH  writeback index
- data_writeReg  in  DATA_WIDTH  writeback data
- ctrl_readReg  in  NUM_READ*ADDR_WIDTH  read indices; port k uses slice [k*ADDR_WIDTH +: ADDR_WIDTH]
- data_readReg  out  NUM_READ*DATA_WIDTH  read data; port k uses slice [k*DATA_WIDTH +: DATA_WIDTH]
- busy_read  out  NUM_READ  port k reads a register with an outstanding producer
- ctrl_reserveEnable  in  1  decode marks a destination as pending
- ctrl_reserveReg  in  ADDR_WIDTH  destination index to reserve
- busy_count  out  ADDR_WIDTH+1  registered number of set busy bits
- LED  out  TAP_WIDTH  tap of register TAP_REG

## Operation
- Storage: DEPTH x DATA_WIDTH flops plus DEPTH busy bits.
- Write path:
  - On a rising edge with ctrl_writeEnable=1, reg[ctrl_writeReg] <= data_writeReg and busy[ctrl_writeReg] <= 0.
  - When ZERO_REG=1, a write to index 0 is ignored.
- Reserve path:
  - On a rising edge with ctrl_reserveEnable=1, busy[ctrl_reserveReg] <= 1.
  - When ZERO_REG=1, a reserve of index 0 is ignored.
- Simultaneous write and reserve:
  - Same index: the data is written and the busy bit ends at 1, because the reserve represents a newer producer.
  - Different indices: both take effect independently.
- Read path (combinational, per port k):
  - data_readReg[k] = reg[idx_k].
  - Bypass override: when BYPASS=1, ctrl_writeEnable=1 and ctrl_writeReg == idx_k (and idx_k != 0 when ZERO_REG=1), the port returns data_writeReg.
  - Index 0 with ZERO_REG=1 always reads 0.
- Busy report (combinational, per port k):
  - busy_read[k] = busy[idx_k].
  - Cleared by the bypass condition above when BYPASS=1.
  - Index 0 with ZERO_REG=1 always reports 0.
  - The reserve in the same cycle does not affect busy_read until the next cycle.
- busy_count is updated every edge by the net delta:
  - +1 for a reserve that sets a previously clear bit.
  - -1 for a write that clears a set bit not simultaneously re-reserved.
  - It is never recomputed by a popcount loop; it must still equal popcount(busy) at all times.
- LED is the TAP_WIDTH LSBs of reg[TAP_REG], taken from storage (no bypass).

## Timing
- Reset (ctrl_reset_n=0, asynchronous):
  - All registers cleared to 0, all busy bits 0, busy_count=0.
  - Therefore LED=0, data_readReg=0 and busy_read=0 (unless bypass is active).
- Reset release is synchronous-safe: the first edge after deassertion performs normal writes and reserves.
- Write latency: 1 edge to storage; 0 cycles to readers when BYPASS=1.
- Reserve latency: 1 edge; busy_read is visible from the following cycle.
- busy_count reflects the state after each edge.
- All read ports are independent, and any number of ports may read the same index.
- Reset asserted mid-operation discards any write or reserve in progress; no partial update is permitted.

## Test plan
- Reset then read all 32 indices on both ports -> all data 0, busy_read=0, busy_count=0, LED=0.
- Write 0xDEADBEEF to r5, then read r5 on port 1 the next cycle -> 0xDEADBEEF; write 0x1234 to r0 -> r0 still reads 0.
- Bypass: write r7=0xA5A5A5A5 while port 0 reads r7 in the same cycle -> port 0 shows 0xA5A5A5A5 combinationally; with BYPASS=0 it shows the old value 0.
- Scoreboard:
  - Reserve r3 -> next cycle busy_read=1 on the port reading r3, busy_count=1.
  - Write r3 -> busy clears, busy_count=0.
  - Reserve and write r3 in the same cycle -> data updated, busy stays 1, count unchanged.
- Reserve r1, r2 and r4 in consecutive cycles, then assert ctrl_reset_n=0 between edges -> outputs immediately 0 and busy_count=0 without a clock.
- Write 0x0001ABCD to r16 -> LED=0xABCD; parameter sweep NUM_READ=4, DATA_WIDTH=16, ADDR_WIDTH=3 -> all ports read independently and busy_count tops out at 7 with ZERO_REG=1.
